control_sequencer: RTL
======================

# control_sequencer

Hardwired control unit for the datapath. It runs a one-state-per-clock fetch/execute sequence (T0..T5) and drives the datapath's register-enable, bus-select, memory and ALU-select strobes. It decodes the 32-bit instruction latched in IR and supports register-register ALU ops, optional register-immediate ops, nop and halt. It sits between IR and the datapath control pins, replacing the hand-driven strobes used during bring-up.

## Interface
Parameters:
- NREGS, 16, number of general registers; width of the one-hot Rin/Rout vectors.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; forces state RESET.
- IR  in  32  instruction register contents. opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0].
- MemReady  in  1  memory read data valid on Mdatain this cycle.
- Stop  in  1  level request to halt after the current instruction.
- PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin, Yin, Cout  out  1 each  datapath strobes. Cout places the sign-extended C on the bus.
- Rin  out  NREGS  one-hot register load enable.
- Rout  out  NREGS  one-hot register bus drive.
- AluOp  out  4  ALU select: 0000 none, 0001 add, 0010 sub, 0011 and, 0100 or, 0101 shr, 0110 shl.
- Run  out  1  high while sequencing; low in RESET and HALT.
- IllegalOp  out  1  one-cycle pulse in T2 when the opcode is undefined.

## Operation
- States: RESET, T0, T1, T2, T3, T4, T5, HALT (3-bit encoding, one state per cycle except T1 wait).
- RESET -> T0 on first clock after Reset deasserts.
- T0: PCout, MARin, IncPC, Zin.
- T1: ZLOout, PCin, Read, MDRin. Hold in T1 while MemReady=0. PCin is asserted only in the cycle where MemReady=1, so PC updates exactly once.
- T2: MDRout, IRin. Next state from the opcode in Mdatain via IR on the following edge (decode uses IR in T3..T5):
  - ALU ops 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl -> T3.
  - 01100 addi, 01101 andi, 01110 ori -> T3.
  - 11010 nop -> T0.
  - 11011 halt -> HALT.
  - Any other opcode -> T0, with IllegalOp pulsed.
- R-type: T3 Rout=onehot(Rb), Yin. T4 Rout=onehot(Rc), AluOp=op, Zin. T5 ZLOout, Rin=onehot(Ra).
- Immediate: T3 Rout=onehot(Rb), Yin. T4 Cout, AluOp=op, Zin. T5 ZLOout, Rin=onehot(Ra).
- After T5: if Stop=1 -> HALT, else -> T0.
- HALT is absorbing; only Reset leaves it.
- Outputs are a Moore decode of the state register and IR. At most one bus driver (PCout, ZLOout, MDRout, Cout, any Rout bit) is active per cycle.
- Ra=Rb permitted. Rin and Rout are never both nonzero in the same cycle.

## Timing
- Reset value of every output is 0, including Run and IllegalOp. Rin and Rout are 16'h0000.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronous); no partial register write completes.
- Latency with MemReady tied high: ALU or immediate instruction 6 cycles; nop or illegal 3 cycles; halt reaches HALT 3 cycles after T0.
- Each MemReady=0 cycle in T1 adds one cycle.
- Stop is sampled only in T5. Stop asserted during T0..T4 completes the instruction; Stop deasserted before T5 is ignored.
- Run rises in the T0 following RESET. Run falls on entry to HALT.

## Configuration
- CTRL_IMMEDIATE_EN defined: addi, andi and ori decode as above, and Cout is driven.
- CTRL_IMMEDIATE_EN undefined: opcodes 01100, 01101 and 01110 are illegal (T2 -> T0 with IllegalOp pulse), and Cout is tied to 0.

## Test plan
- Reset held 3 cycles, then released with MemReady=1 -> all outputs 0 during reset; T0 on the first edge with PCout=MARin=IncPC=Zin=1; Run=1.
- IR=32'h28918000 (and R1,R2,R3) -> T3: Rout=16'h0004, Yin=1. T4: Rout=16'h0008, AluOp=0011, Zin=1. T5: Rin=16'h0002, ZLOout=1. Then T0.
- MemReady low for 2 cycles in T1 -> T1 lasts 3 cycles; Read=MDRin=1 throughout; PCin=1 only in the third cycle.
- IR opcode 11111 -> IllegalOp=1 for one cycle in T2, then T0. Opcode 11011 -> HALT, Run=0, outputs stay 0 for 10 cycles.
- Stop=1 raised in T3 of an add -> T4 and T5 complete with Rin=onehot(Ra), then HALT.
- Reset pulsed during T4 -> Zin and Rout clear asynchronously; T0 on the first edge after release; CTRL_IMMEDIATE_EN build: IR=32'h60880005 (addi R1,R1,5) -> T4 Cout=1, AluOp=0001.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired T0..T5 fetch/execute control unit: decodes IR and drives the datapath strobes.
// Build option CTRL_IMMEDIATE_EN adds addi/andi/ori decode and drives Cout.

module control_sequencer #(
   parameter int NREGS = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      ir_i,
   input  logic             mem_ready_i,
   input  logic             stop_i,
   output logic             pc_out_o,
   output logic             mar_in_o,
   output logic             inc_pc_o,
   output logic             z_in_o,
   output logic             zlo_out_o,
   output logic             pc_in_o,
   output logic             read_o,
   output logic             mdr_in_o,
   output logic             mdr_out_o,
   output logic             ir_in_o,
   output logic             y_in_o,
   output logic             c_out_o,
   output logic [NREGS-1:0] rin_o,
   output logic [NREGS-1:0] rout_o,
   output logic [3:0]       alu_op_o,
   output logic             run_o,
   output logic             illegal_op_o
);

   // state  | meaning
   // RESET  | held in reset, every strobe low
   // T0     | PC onto bus into MAR, PC+1 into Z
   // T1     | memory read into MDR, wait on MemReady; PC <- Z on the ready cycle
   // T2     | MDR into IR, opcode decides the next state
   // T3     | Rb into Y
   // T4     | ALU op on Y and Rc (or C) into Z
   // T5     | Z into Ra, Stop sampled
   // HALT   | stopped, only reset leaves
   localparam logic [2:0] S_RESET = 3'd0;
   localparam logic [2:0] S_T0    = 3'd1;
   localparam logic [2:0] S_T1    = 3'd2;
   localparam logic [2:0] S_T2    = 3'd3;
   localparam logic [2:0] S_T3    = 3'd4;
   localparam logic [2:0] S_T4    = 3'd5;
   localparam logic [2:0] S_T5    = 3'd6;
   localparam logic [2:0] S_HALT  = 3'd7;

   logic [2:0] state_q, state_d;
   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_rtype, is_imm, is_nop, is_halt, legal;
   logic [3:0] alu_code;
   logic       unused_ir;

   assign opcode    = ir_i[31:27];
   assign ra        = ir_i[26:23];
   assign rb        = ir_i[22:19];
   assign rc        = ir_i[18:15];
   // The constant field is steered onto the bus by the datapath; control never looks at it.
   assign unused_ir = ^ir_i[14:0];

   function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
      logic [NREGS-1:0] v;
      v = '0;
      for (int i = 0; i < NREGS; i++) v[i] = (int'(idx) == i);
      return v;
   endfunction

   always_comb begin
      is_rtype = 1'b0;
      is_imm   = 1'b0;
      alu_code = 4'b0000;
      case (opcode)
         5'b00011: begin is_rtype = 1'b1; alu_code = 4'b0001; end
         5'b00100: begin is_rtype = 1'b1; alu_code = 4'b0010; end
         5'b00101: begin is_rtype = 1'b1; alu_code = 4'b0011; end
         5'b00110: begin is_rtype = 1'b1; alu_code = 4'b0100; end
         5'b00111: begin is_rtype = 1'b1; alu_code = 4'b0101; end
         5'b01000: begin is_rtype = 1'b1; alu_code = 4'b0110; end
`ifdef CTRL_IMMEDIATE_EN
         5'b01100: begin is_imm = 1'b1; alu_code = 4'b0001; end
         5'b01101: begin is_imm = 1'b1; alu_code = 4'b0011; end
         5'b01110: begin is_imm = 1'b1; alu_code = 4'b0100; end
`endif
         default: ;
      endcase
      is_nop  = (opcode == 5'b11010);
      is_halt = (opcode == 5'b11011);
      legal   = is_rtype | is_imm | is_nop | is_halt;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = mem_ready_i ? S_T2 : S_T1;
         S_T2: begin
            if (is_rtype || is_imm) state_d = S_T3;
            else if (is_halt)       state_d = S_HALT;
            else                    state_d = S_T0;
         end
         S_T3:    state_d = S_T4;
         S_T4:    state_d = S_T5;
         S_T5:    state_d = stop_i ? S_HALT : S_T0;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_RESET;
      else       state_q <= state_d;
   end

   always_comb begin
      pc_out_o     = 1'b0;
      mar_in_o     = 1'b0;
      inc_pc_o     = 1'b0;
      z_in_o       = 1'b0;
      zlo_out_o    = 1'b0;
      pc_in_o      = 1'b0;
      read_o       = 1'b0;
      mdr_in_o     = 1'b0;
      mdr_out_o    = 1'b0;
      ir_in_o      = 1'b0;
      y_in_o       = 1'b0;
      c_out_o      = 1'b0;
      rin_o        = '0;
      rout_o       = '0;
      alu_op_o     = 4'b0000;
      run_o        = 1'b0;
      illegal_op_o = 1'b0;
      case (state_q)
         S_T0: begin
            pc_out_o = 1'b1;
            mar_in_o = 1'b1;
            inc_pc_o = 1'b1;
            z_in_o   = 1'b1;
            run_o    = 1'b1;
         end
         S_T1: begin
            zlo_out_o = 1'b1;
            pc_in_o   = mem_ready_i;
            read_o    = 1'b1;
            mdr_in_o  = 1'b1;
            run_o     = 1'b1;
         end
         S_T2: begin
            mdr_out_o    = 1'b1;
            ir_in_o      = 1'b1;
            illegal_op_o = ~legal;
            run_o        = 1'b1;
         end
         S_T3: begin
            rout_o = onehot(rb);
            y_in_o = 1'b1;
            run_o  = 1'b1;
         end
         S_T4: begin
            // Second operand comes from Rc for register ops, from C for immediates.
            if (is_imm) c_out_o = 1'b1;
            else        rout_o  = onehot(rc);
            alu_op_o = alu_code;
            z_in_o   = 1'b1;
            run_o    = 1'b1;
         end
         S_T5: begin
            zlo_out_o = 1'b1;
            rin_o     = onehot(ra);
            run_o     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
